// File: rtl/d_reg_pipeline.sv
// WIDTH-bit, DEPTH-stage register pipeline with valid/ready flow control,
// bubble collapsing, synchronous flush and a registered occupancy count.
module d_reg_pipeline #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             in_xfer;
  logic             out_xfer;

  // A stage advances when its successor is empty or itself advancing;
  // resolved from the output end so out_ready ripples back to stage 0.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = v_q[DEPTH-1] & out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = v_q[i] & (~v_q[i+1] | adv[i+1]);
    end
  end

  assign in_ready  = ~flush & (~v_q[0] | adv[0]);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = v_q[DEPTH-1] & out_ready;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (in_xfer) begin
      v_d[0] = 1'b1;
      d_d[0] = in_data;
    end else if (adv[0]) begin
      v_d[0] = 1'b0;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (adv[i-1]) begin
        v_d[i] = 1'b1;
        d_d[i] = d_q[i-1];
      end else if (adv[i]) begin
        v_d[i] = 1'b0;
      end
    end
    count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
    // Flush drops every in-flight word; stage data is left as don't-care.
    if (flush) begin
      v_d     = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      d_q     <= d_d;
    end
  end

endmodule

// File: tb/tb_d_reg_pipeline.sv
// Bench for d_reg_pipeline: a DEPTH=4/WIDTH=8 and a DEPTH=1/WIDTH=16 instance
// share stimulus; a queue-of-positions model predicts the selected instance.
module tb_d_reg_pipeline;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid;
  logic [7:0]  a_out_data;
  logic [2:0]  a_count;
  logic        b_in_ready, b_out_valid;
  logic [15:0] b_out_data;
  logic [0:0]  b_count;

  bit          sel = 1'b0;
  logic        o_ready, o_valid;
  logic [15:0] o_data;
  logic [2:0]  o_count;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  d_reg_pipeline #(.WIDTH(8), .DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data[7:0]),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .count(a_count)
  );

  d_reg_pipeline #(.WIDTH(16), .DEPTH(1)) u_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .count(b_count)
  );

  assign o_ready = sel ? b_in_ready : a_in_ready;
  assign o_valid = sel ? b_out_valid : a_out_valid;
  assign o_data  = sel ? b_out_data : {8'h00, a_out_data};
  assign o_count = sel ? {2'b00, b_count} : a_count;

  // Reference model: words in flight, oldest first, each with its stage index.
  // A word moves one stage per cycle but never onto or past the word ahead.
  int          mdepth = 4;
  logic [15:0] mmask  = 16'h00FF;
  logic [15:0] mq_d[$];
  int          mq_p[$];

  function automatic int m_count();
    return mq_d.size();
  endfunction

  function automatic bit m_out_valid();
    return (mq_d.size() > 0) && (mq_p[0] == mdepth - 1);
  endfunction

  function automatic logic [15:0] m_out_data();
    return mq_d[0];
  endfunction

  function automatic int m_last_new_pos(bit ordy);
    int lim = mdepth;
    for (int i = 0; i < mq_p.size(); i++) begin
      if (!(i == 0 && mq_p[0] == mdepth - 1 && ordy))
        lim = (mq_p[i] + 1 < lim - 1) ? mq_p[i] + 1 : lim - 1;
    end
    return lim;
  endfunction

  function automatic bit m_in_ready(bit fl, bit ordy);
    return !fl && (m_last_new_pos(ordy) >= 1);
  endfunction

  task automatic m_edge();
    bit rdy;
    bit drop;
    int lim;
    if (reset || flush) begin
      mq_d.delete();
      mq_p.delete();
    end else begin
      rdy  = m_in_ready(1'b0, out_ready);
      drop = 1'b0;
      lim  = mdepth;
      for (int i = 0; i < mq_p.size(); i++) begin
        if (i == 0 && mq_p[0] == mdepth - 1 && out_ready) drop = 1'b1;
        else begin
          mq_p[i] = (mq_p[i] + 1 < lim - 1) ? mq_p[i] + 1 : lim - 1;
          lim = mq_p[i];
        end
      end
      if (drop) begin
        void'(mq_d.pop_front());
        void'(mq_p.pop_front());
      end
      if (in_valid && rdy) begin
        mq_d.push_back(in_data & mmask);
        mq_p.push_back(0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    sel = 1'b0; mdepth = 4; mmask = 16'h00FF;
    reset = 1'b1; in_valid = 1'b1; in_data = 16'h00AA; out_ready = 1'b1; flush = 1'b0;
    repeat (2) tick();
    #1;
    n_assert++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_out_valid got=%b exp=0", a_out_valid); end
    n_assert++; if (a_out_data !== 8'h00) begin n_fail++; $display("FAIL reset_a_out_data got=%h exp=00", a_out_data); end
    n_assert++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL reset_a_count got=%0d exp=0", a_count); end
    n_assert++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_out_valid got=%b exp=0", b_out_valid); end
    n_assert++; if (b_out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_b_out_data got=%h exp=0000", b_out_data); end
    n_assert++; if (b_count !== 1'b0) begin n_fail++; $display("FAIL reset_b_count got=%0d exp=0", b_count); end
    reset = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_assert++;
      if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_emit cyc=%0d got=%b exp=0", cyc, o_valid); end
      tick();
    end
    $display("test_reset done cyc=%0d", cyc);
  endtask

  task automatic test_streaming();
    int nxt = 1;
    int first_acc = -1;
    int first_out = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      in_valid = (nxt <= 8); in_data = 16'(nxt);
      #1;
      n_assert++; if (o_ready !== m_in_ready(flush, out_ready)) begin n_fail++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=%b", cyc, o_ready, m_in_ready(flush, out_ready)); end
      n_assert++; if (o_valid !== m_out_valid()) begin n_fail++; $display("FAIL stream_out_valid cyc=%0d got=%b exp=%b", cyc, o_valid, m_out_valid()); end
      if (m_out_valid()) begin
        n_assert++; if (o_data !== m_out_data()) begin n_fail++; $display("FAIL stream_out_data cyc=%0d got=%h exp=%h", cyc, o_data, m_out_data()); end
      end
      n_assert++; if (o_count !== 3'(m_count())) begin n_fail++; $display("FAIL stream_count cyc=%0d got=%0d exp=%0d", cyc, o_count, m_count()); end
      if (in_valid && o_ready && nxt == 1) first_acc = c;
      if (o_valid && o_data == 16'h0001 && first_out < 0) first_out = c;
      if (in_valid && o_ready) nxt++;
      tick();
    end
    in_valid = 1'b0;
    n_assert++;
    if (first_acc < 0 || first_out - first_acc != 4) begin
      n_fail++; $display("FAIL stream_latency got=%0d exp=4", first_out - first_acc);
    end
    $display("test_streaming done cyc=%0d", cyc);
  endtask

  task automatic test_backpressure();
    int acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_data = 16'h0030 + 16'(acc);
      #1;
      n_assert++; if (o_ready !== m_in_ready(flush, out_ready)) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", cyc, o_ready, m_in_ready(flush, out_ready)); end
      if (o_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_assert++; if (acc != 4) begin n_fail++; $display("FAIL bp_accepted got=%0d exp=4", acc); end
    n_assert++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got=%b exp=0", o_ready); end
    n_assert++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL bp_full_count got=%0d exp=4", o_count); end
    out_ready = 1'b1;
    #1;
    n_assert++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", o_ready); end
    for (int c = 0; c < 6; c++) begin
      #1;
      n_assert++; if (o_valid !== m_out_valid()) begin n_fail++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=%b", cyc, o_valid, m_out_valid()); end
      if (m_out_valid()) begin
        n_assert++; if (o_data !== m_out_data()) begin n_fail++; $display("FAIL bp_out_data cyc=%0d got=%h exp=%h", cyc, o_data, m_out_data()); end
      end
      tick();
    end
    $display("test_backpressure done cyc=%0d", cyc);
  endtask

  task automatic test_bubble();
    logic [15:0] seen[$];
    bit          vpat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] dpat[4] = '{16'h0011, 16'h0000, 16'h0000, 16'h0022};
    out_ready = 1'b0;
    for (int c = 0; c < 9; c++) begin
      in_valid = (c < 4) ? vpat[c] : 1'b0;
      in_data  = (c < 4) ? dpat[c] : 16'h0000;
      #1;
      n_assert++; if (o_count !== 3'(m_count())) begin n_fail++; $display("FAIL bubble_count cyc=%0d got=%0d exp=%0d", cyc, o_count, m_count()); end
      n_assert++; if (o_valid !== m_out_valid()) begin n_fail++; $display("FAIL bubble_out_valid cyc=%0d got=%b exp=%b", cyc, o_valid, m_out_valid()); end
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_assert++; if (o_count !== 3'd2) begin n_fail++; $display("FAIL bubble_settled_count got=%0d exp=2", o_count); end
    n_assert++; if (o_valid !== 1'b1 || o_data !== 16'h0011) begin n_fail++; $display("FAIL bubble_head got=%b/%h exp=1/0011", o_valid, o_data); end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (o_valid) seen.push_back(o_data);
      tick();
    end
    n_assert++;
    if (seen.size() != 2 || seen[0] !== 16'h0011 || seen[1] !== 16'h0022) begin
      n_fail++; $display("FAIL bubble_order got_n=%0d exp=2 words 11,22", seen.size());
    end
    $display("test_bubble done cyc=%0d", cyc);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_data = 16'h0041 + 16'(c);
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h00FF;
    #1;
    n_assert++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=0", o_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_assert++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL flush_count got=%0d exp=0", o_count); end
    n_assert++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b exp=0", o_valid); end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_assert++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_emit cyc=%0d got=%b/%h exp=0", cyc, o_valid, o_data); end
      tick();
    end
    $display("test_flush done cyc=%0d", cyc);
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 40) == 0;
      in_data   = 16'($urandom);
      #1;
      n_assert++; if (o_ready !== m_in_ready(flush, out_ready)) begin n_fail++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", cyc, o_ready, m_in_ready(flush, out_ready)); end
      n_assert++; if (o_valid !== m_out_valid()) begin n_fail++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", cyc, o_valid, m_out_valid()); end
      if (m_out_valid()) begin
        n_assert++; if (o_data !== m_out_data()) begin n_fail++; $display("FAIL rand_out_data cyc=%0d got=%h exp=%h", cyc, o_data, m_out_data()); end
      end
      n_assert++; if (o_count !== 3'(m_count())) begin n_fail++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, o_count, m_count()); end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
    $display("test_random done cyc=%0d", cyc);
  endtask

  task automatic test_depth1();
    logic [15:0] sent[$];
    logic [15:0] exp_w;
    sel = 1'b1; mdepth = 1; mmask = 16'hFFFF;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 48; c++) begin
      in_valid  = (c < 40);
      in_data   = 16'($urandom);
      out_ready = (c % 2) == 0;
      #1;
      n_assert++; if (o_ready !== m_in_ready(flush, out_ready)) begin n_fail++; $display("FAIL d1_in_ready cyc=%0d got=%b exp=%b", cyc, o_ready, m_in_ready(flush, out_ready)); end
      n_assert++; if (o_valid !== m_out_valid()) begin n_fail++; $display("FAIL d1_out_valid cyc=%0d got=%b exp=%b", cyc, o_valid, m_out_valid()); end
      n_assert++; if (o_count !== 3'(m_count())) begin n_fail++; $display("FAIL d1_count cyc=%0d got=%0d exp=%0d", cyc, o_count, m_count()); end
      if (o_valid && out_ready) begin
        n_assert++;
        if (sent.size() == 0) begin
          n_fail++; $display("FAIL d1_dup cyc=%0d got=%h exp=none", cyc, o_data);
        end else begin
          exp_w = sent.pop_front();
          if (o_data !== exp_w) begin n_fail++; $display("FAIL d1_data cyc=%0d got=%h exp=%h", cyc, o_data, exp_w); end
        end
      end
      if (in_valid && o_ready) sent.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    n_assert++; if (sent.size() != 0) begin n_fail++; $display("FAIL d1_loss got=%0d pending exp=0", sent.size()); end
    $display("test_depth1 done cyc=%0d", cyc);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_random();
    test_depth1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
